// File: rtl/fetch_pc_unit_if.sv
// Signal bundle between the fetch PC unit and its surroundings:
// next-PC mux, instruction memory and the decode stage.
interface fetch_pc_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] next_pc;
  logic             branch_taken;
  logic             stall;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             if_valid;
  logic [WIDTH-1:0] if_instr;
  logic [WIDTH-1:0] if_pc;

  modport master (
    input  next_pc, branch_taken, stall, imem_ack, imem_rdata,
    output imem_req, imem_addr, pc, pc_plus4, if_valid, if_instr, if_pc
  );

  modport slave (
    output next_pc, branch_taken, stall, imem_ack, imem_rdata,
    input  imem_req, imem_addr, pc, pc_plus4, if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch core: PC register, single-outstanding imem request,
// IF/ID output register backed by a one-entry skid buffer.
module fetch_pc_unit #(
  parameter int unsigned          WIDTH    = 32,
  parameter logic [WIDTH-1:0]     RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  fetch_pc_unit_if.master  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] redirect_q, redirect_d;
  logic             if_valid_q, if_valid_d;
  logic [WIDTH-1:0] if_instr_q, if_instr_d;
  logic [WIDTH-1:0] if_pc_q, if_pc_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic             accept;

  assign accept        = !if_valid_q || !bus.stall;
  assign bus.imem_req  = (state_q == FETCH) || (state_q == DRAIN);
  assign bus.imem_addr = pc_q;
  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_q + WIDTH'(4);
  assign bus.if_valid  = if_valid_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_pc     = if_pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redirect_d   = redirect_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    // Consumption by decode; any load below re-asserts valid.
    if_valid_d   = if_valid_q && bus.stall;

    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (bus.branch_taken && bus.imem_ack) begin
          pc_d = bus.next_pc;
        end else if (bus.branch_taken) begin
          // Address must stay stable until the in-flight ack, so park the target.
          redirect_d = bus.next_pc;
          state_d    = DRAIN;
        end else if (bus.imem_ack) begin
          pc_d = bus.next_pc;
          if (accept) begin
            if_valid_d = 1'b1;
            if_instr_d = bus.imem_rdata;
            if_pc_d    = pc_q;
          end else begin
            skid_valid_d = 1'b1;
            skid_instr_d = bus.imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = HOLD;
          end
        end
      end
      DRAIN: begin
        if (bus.imem_ack) begin
          pc_d    = bus.branch_taken ? bus.next_pc : redirect_q;
          state_d = FETCH;
        end else if (bus.branch_taken) begin
          redirect_d = bus.next_pc;
        end
      end
      HOLD: begin
        if (bus.branch_taken) begin
          pc_d    = bus.next_pc;
          state_d = FETCH;
        end else if (accept) begin
          if_valid_d   = skid_valid_q;
          if_instr_d   = skid_instr_q;
          if_pc_d      = skid_pc_q;
          skid_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.branch_taken) begin
      if_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      redirect_q   <= '0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

endmodule
